// File: rtl/mem_wb_skid.sv
// rtl/mem_wb_skid.sv - MEM/WB pipeline stage with a 2-entry skid buffer
// Legacy stall vector, flush and x0 write-suppress; OUT slot drives wb_*, SKID absorbs backpressure.
module mem_wb_skid #(
   parameter int DATA_W        = 64,
   parameter int ADDR_W        = 5,
   parameter int HILO_W        = 32,
   parameter int NUM_PORTS     = 1,
   parameter int STAGE_IDX     = 4,
   parameter int STALL_W       = 6,
   parameter int ZERO_SUPPRESS = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [STALL_W-1:0]            stall,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [NUM_PORTS*ADDR_W-1:0]   mem_wd,
   input  logic [NUM_PORTS-1:0]          mem_wreg,
   input  logic [NUM_PORTS*DATA_W-1:0]   mem_wdata,
   input  logic [HILO_W-1:0]             mem_hi,
   input  logic [HILO_W-1:0]             mem_lo,
   input  logic                          mem_whilo,
   input  logic                          wb_ready,
   output logic                          wb_valid,
   output logic [NUM_PORTS*ADDR_W-1:0]   wb_wd,
   output logic [NUM_PORTS-1:0]          wb_wreg,
   output logic [NUM_PORTS*DATA_W-1:0]   wb_wdata,
   output logic [HILO_W-1:0]             wb_hi,
   output logic [HILO_W-1:0]             wb_lo,
   output logic                          wb_whilo,
   output logic [1:0]                    occupancy
);

   localparam int ENT_W = NUM_PORTS*ADDR_W + NUM_PORTS + NUM_PORTS*DATA_W + 2*HILO_W + 1;

   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_ONE   = 2'd1;
   localparam logic [1:0] S_FULL  = 2'd2;

   logic [ENT_W-1:0]     in_entry;
   logic [ENT_W-1:0]     out_q, out_d;
   logic [ENT_W-1:0]     skid_q, skid_d;
   logic [ENT_W-1:0]     wb_entry;
   logic [1:0]           occ_q, occ_d;
   logic                 in_ready_q;
   logic [NUM_PORTS-1:0] in_wreg;
   logic                 accept;
   logic                 drain;
   logic                 unused_stall;

   // Writes to x0 are architecturally dead; drop the enable so WB never sees them.
   always_comb begin
      in_wreg = mem_wreg;
      if (ZERO_SUPPRESS != 0) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (mem_wd[i*ADDR_W +: ADDR_W] == '0) in_wreg[i] = 1'b0;
         end
      end
   end

   assign in_entry     = {mem_wd, in_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo};
   assign unused_stall = ^stall;

   assign wb_valid = (occ_q != S_EMPTY);
   assign accept   = in_valid & in_ready_q & ~stall[STAGE_IDX];
   // A stalled downstream stage is frozen, so nothing retires even if wb_ready is high.
   assign drain    = wb_valid & wb_ready & ~stall[STAGE_IDX+1];

   always_comb begin
      occ_d  = occ_q;
      out_d  = out_q;
      skid_d = skid_q;
      case (occ_q)
         S_EMPTY: begin
            if (accept) begin
               out_d = in_entry;
               occ_d = S_ONE;
            end
         end
         S_ONE: begin
            if (accept && drain) begin
               out_d = in_entry;
            end else if (accept) begin
               skid_d = in_entry;
               occ_d  = S_FULL;
            end else if (drain) begin
               occ_d = S_EMPTY;
            end
         end
         S_FULL: begin
            if (drain) begin
               out_d = skid_q;
               occ_d = S_ONE;
            end
         end
         default: occ_d = S_EMPTY;
      endcase
      if (flush) occ_d = S_EMPTY;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         occ_q      <= S_EMPTY;
         out_q      <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         occ_q      <= occ_d;
         out_q      <= out_d;
         skid_q     <= skid_d;
         in_ready_q <= (occ_d != S_FULL);
      end
   end

   // Idle output is forced to a NOP regardless of stale slot contents.
   assign wb_entry = wb_valid ? out_q : '0;
   assign {wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo} = wb_entry;
   assign in_ready  = in_ready_q;
   assign occupancy = occ_q;

endmodule

// File: tb/tb_mem_wb_skid.sv
// tb/tb_mem_wb_skid.sv - directed self-checking bench for mem_wb_skid
// Two write-back lanes so the x0 suppress path is exercised alongside streaming, backpressure, bubble and flush.
module tb_mem_wb_skid;

   localparam int NP = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [5:0]    stall;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [9:0]    mem_wd;
   logic [1:0]    mem_wreg;
   logic [127:0]  mem_wdata;
   logic [31:0]   mem_hi, mem_lo;
   logic          mem_whilo;
   logic          wb_ready;
   logic          wb_valid;
   logic [9:0]    wb_wd;
   logic [1:0]    wb_wreg;
   logic [127:0]  wb_wdata;
   logic [31:0]   wb_hi, wb_lo;
   logic          wb_whilo;
   logic [1:0]    occupancy;

   int n_checks = 0;
   int n_fails  = 0;

   mem_wb_skid #(.DATA_W(64), .ADDR_W(5), .HILO_W(32), .NUM_PORTS(NP),
                 .STAGE_IDX(4), .STALL_W(6), .ZERO_SUPPRESS(1)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
      .wb_ready(wb_ready), .wb_valid(wb_valid),
      .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
      .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [127:0] d);
      in_valid  = 1'b1;
      mem_wdata = d;
   endtask

   initial begin
      rst = 1'b0; stall = '0; flush = 1'b0; in_valid = 1'b1;
      mem_wd = {5'd2, 5'd1}; mem_wreg = 2'b11; mem_wdata = 128'hdead;
      mem_hi = 32'h0; mem_lo = 32'h0; mem_whilo = 1'b0; wb_ready = 1'b1;

      // reset held two cycles with in_valid asserted
      tick(); tick();
      check("rst_valid", wb_valid, 0);
      check("rst_ready", in_ready, 1);
      check("rst_occ", occupancy, 0);
      check("rst_wdata", wb_wdata, 0);
      check("rst_wd", wb_wd, 0);
      check("rst_wreg", wb_wreg, 0);
      check("rst_whilo", wb_whilo, 0);

      // streaming: 8 back-to-back entries, each visible one cycle later
      rst = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         send(128'(k));
         tick();
         check("stream_valid", wb_valid, 1);
         check("stream_wdata", wb_wdata, 128'(k));
         check("stream_occ", occupancy, 1);
      end
      check("stream_wreg", wb_wreg, 2'b11);
      check("stream_wd", wb_wd, {5'd2, 5'd1});
      in_valid = 1'b0;
      tick();
      check("stream_drained", wb_valid, 0);
      check("stream_occ0", occupancy, 0);

      // backpressure: A on output, B in skid, C held off
      wb_ready = 1'b0;
      send(128'hA); tick();
      check("bp_a_out", wb_wdata, 128'hA);
      check("bp_ready1", in_ready, 1);
      send(128'hB); tick();
      check("bp_occ2", occupancy, 2);
      check("bp_ready0", in_ready, 0);
      check("bp_a_hold", wb_wdata, 128'hA);
      send(128'hC); tick();
      check("bp_c_held", occupancy, 2);
      check("bp_a_still", wb_wdata, 128'hA);
      wb_ready = 1'b1; tick();
      check("bp_b_out", wb_wdata, 128'hB);
      check("bp_occ1", occupancy, 1);
      tick();
      check("bp_c_out", wb_wdata, 128'hC);
      check("bp_c_valid", wb_valid, 1);
      in_valid = 1'b0; tick();
      check("bp_empty", wb_valid, 0);

      // legacy bubble: own stall bit blocks intake, WB still drains
      wb_ready = 1'b0; send(128'hD); tick();
      check("bub_setup", occupancy, 1);
      send(128'hE); stall = 6'b010000; wb_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("bub_valid", wb_valid, 0);
         check("bub_wreg", wb_wreg, 0);
         check("bub_occ", occupancy, 0);
      end
      stall = '0; in_valid = 1'b0;

      // downstream stall freezes drain despite wb_ready
      wb_ready = 1'b0; send(128'hF); tick();
      in_valid = 1'b0; stall = 6'b100000; wb_ready = 1'b1; tick();
      check("frz_occ", occupancy, 1);
      check("frz_data", wb_wdata, 128'hF);
      stall = '0; tick();
      check("frz_release", occupancy, 0);

      // flush from full drops the same-cycle input
      wb_ready = 1'b0;
      send(128'h10); tick();
      send(128'h11); tick();
      check("fl_full", occupancy, 2);
      send(128'h12); flush = 1'b1; tick();
      check("fl_occ", occupancy, 0);
      check("fl_valid", wb_valid, 0);
      check("fl_ready", in_ready, 1);
      check("fl_wdata", wb_wdata, 0);
      flush = 1'b0; in_valid = 1'b0; tick();
      check("fl_dropped", occupancy, 0);

      // zero-suppress on lane 0, hi/lo passthrough
      mem_wd = {5'd3, 5'd0}; mem_wreg = 2'b11;
      mem_hi = 32'h1234_5678; mem_lo = 32'h9abc_def0; mem_whilo = 1'b1;
      send({64'hBB, 64'hAA}); tick();
      check("zs_wreg", wb_wreg, 2'b10);
      check("zs_wd", wb_wd, {5'd3, 5'd0});
      check("zs_wdata", wb_wdata, {64'hBB, 64'hAA});
      check("zs_hi", wb_hi, 32'h1234_5678);
      check("zs_lo", wb_lo, 32'h9abc_def0);
      check("zs_whilo", wb_whilo, 1);

      // reset mid-operation empties the stage
      in_valid = 1'b0; rst = 1'b0; tick();
      check("mrst_valid", wb_valid, 0);
      check("mrst_occ", occupancy, 0);
      check("mrst_hi", wb_hi, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
